// File: rtl/jump_control_if.sv
// Bundle between the control unit and the jump sequencer: the request side
// (opcode, status flags, PC), the operand-fetch port and the PC-update outputs.
interface jump_control_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [7:0]        opcode;
  logic              n_in;
  logic              z_in;
  logic              c_in;
  logic              b_in;
  logic              v_in;
  logic [ADDR_W-1:0] pc_in;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              busy;
  logic              done;
  logic              taken;
  logic              illegal;

  // Control-unit side: issues jumps, answers operand reads, consumes PC updates.
  modport master (
    output start, opcode, n_in, z_in, c_in, b_in, v_in, pc_in,
    output mem_rdata, mem_ready,
    input  mem_req, mem_addr,
    input  pc_load, pc_next, busy, done, taken, illegal
  );

  modport slave (
    input  start, opcode, n_in, z_in, c_in, b_in, v_in, pc_in,
    input  mem_rdata, mem_ready,
    output mem_req, mem_addr,
    output pc_load, pc_next, busy, done, taken, illegal
  );
endinterface

// File: rtl/jump_control.sv
// Conditional-branch sequencer: decodes a jump opcode against the status flags,
// fetches the target operand when taken, otherwise skips the operand byte.
module jump_control #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          reset_n,
  jump_control_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_pc_load;
  logic [ADDR_W-1:0] r_pc_next;
  logic              r_busy;
  logic              r_done;
  logic              r_taken;
  logic              r_illegal;

  logic              w_legal;
  logic              w_cond;
  logic              w_unused_ok;

  // Low opcode bits are don't-care for decode; upper rdata bits never reach the PC.
  assign w_unused_ok = ^{bus.opcode[1:0], bus.mem_rdata};

  // Condition decode on opcode[7:2] using the live flags of the start cycle.
  always_comb begin
    w_legal = 1'b1;
    w_cond  = 1'b0;
    case (bus.opcode[7:2])
      6'h20:   w_cond = 1'b1;                      // JMP
      6'h24:   w_cond = bus.n_in;                  // JN
      6'h25:   w_cond = ~bus.n_in & ~bus.z_in;     // JP
      6'h26:   w_cond = bus.v_in;                  // JV
      6'h27:   w_cond = ~bus.v_in;                 // JNV
      6'h28:   w_cond = bus.z_in;                  // JZ
      6'h29:   w_cond = ~bus.z_in;                 // JNZ
      6'h2C:   w_cond = bus.c_in;                  // JC
      6'h2D:   w_cond = ~bus.c_in;                 // JNC
      6'h2E:   w_cond = bus.b_in;                  // JB
      6'h2F:   w_cond = ~bus.b_in;                 // JNB
      default: w_legal = 1'b0;
    endcase
  end

  // The decision is resolved on the start edge, so later flag or pc_in
  // changes cannot affect the operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_pc_load  <= 1'b0;
      r_pc_next  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_taken    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (!w_legal) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_illegal <= 1'b1;
            end else if (w_cond) begin
              r_state    <= StRead;
              r_mem_req  <= 1'b1;
              r_mem_addr <= bus.pc_in;
            end else begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_pc_load <= 1'b1;
              r_pc_next <= bus.pc_in + ADDR_W'(1);
            end
          end
        end

        StRead: begin
          if (bus.mem_ready) begin
            r_state   <= StDone;
            r_mem_req <= 1'b0;
            r_pc_next <= bus.mem_rdata[ADDR_W-1:0];
            r_done    <= 1'b1;
            r_pc_load <= 1'b1;
            r_taken   <= 1'b1;
          end
        end

        StDone: begin
          r_state   <= StIdle;
          r_done    <= 1'b0;
          r_pc_load <= 1'b0;
          r_busy    <= 1'b0;
          r_taken   <= 1'b0;
          r_illegal <= 1'b0;
        end

        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
          r_done    <= 1'b0;
          r_pc_load <= 1'b0;
          r_busy    <= 1'b0;
          r_taken   <= 1'b0;
          r_illegal <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.pc_load  = r_pc_load;
  assign bus.pc_next  = r_pc_next;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.taken    = r_taken;
  assign bus.illegal  = r_illegal;

endmodule

// File: tb/tb_jump_control.sv
// Directed bench for jump_control: a vector table of single jumps plus
// hand-written sequences for delayed memory ready and reset during a fetch.
module tb_jump_control;

  logic clk;
  logic reset_n;

  jump_control_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  jump_control #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [4:0] flags;     // {N,Z,C,B,V}
    logic [7:0] pc;
    logic [7:0] rdata;
    logic       exp_taken;
    logic       exp_ill;
    logic [7:0] exp_next;
  } vec_t;

  vec_t vecs [17];
  vec_t vrec;

  int n_cmp;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, ".mem_req"},  {31'd0, bus.mem_req},  32'd0);
    chk({pfx, ".mem_addr"}, {24'd0, bus.mem_addr}, 32'd0);
    chk({pfx, ".pc_load"},  {31'd0, bus.pc_load},  32'd0);
    chk({pfx, ".pc_next"},  {24'd0, bus.pc_next},  32'd0);
    chk({pfx, ".busy"},     {31'd0, bus.busy},     32'd0);
    chk({pfx, ".done"},     {31'd0, bus.done},     32'd0);
    chk({pfx, ".taken"},    {31'd0, bus.taken},    32'd0);
    chk({pfx, ".illegal"},  {31'd0, bus.illegal},  32'd0);
  endtask

  task automatic drive_req(input logic [7:0] op, input logic [4:0] fl, input logic [7:0] pc);
    bus.opcode = op;
    {bus.n_in, bus.z_in, bus.c_in, bus.b_in, bus.v_in} = fl;
    bus.pc_in = pc;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, input string nm);
    drive_req(v.op, v.flags, v.pc);
    bus.start     = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'hA5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, ".c1.busy"}, {31'd0, bus.busy}, 32'd1);
    if (v.exp_taken) begin
      chk({nm, ".c1.mem_req"},  {31'd0, bus.mem_req},  32'd1);
      chk({nm, ".c1.mem_addr"}, {24'd0, bus.mem_addr}, {24'd0, v.pc});
      chk({nm, ".c1.done"},     {31'd0, bus.done},     32'd0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = v.rdata;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
    end
    chk({nm, ".mem_req"},  {31'd0, bus.mem_req},  32'd0);
    chk({nm, ".done"},     {31'd0, bus.done},     32'd1);
    chk({nm, ".taken"},    {31'd0, bus.taken},    {31'd0, v.exp_taken});
    chk({nm, ".illegal"},  {31'd0, bus.illegal},  {31'd0, v.exp_ill});
    chk({nm, ".pc_load"},  {31'd0, bus.pc_load},  {31'd0, ~v.exp_ill});
    chk({nm, ".pc_next"},  {24'd0, bus.pc_next},  {24'd0, v.exp_next});
    @(posedge clk); #1;
    chk({nm, ".post.done"},    {31'd0, bus.done},    32'd0);
    chk({nm, ".post.busy"},    {31'd0, bus.busy},    32'd0);
    chk({nm, ".post.pc_load"}, {31'd0, bus.pc_load}, 32'd0);
    chk({nm, ".post.taken"},   {31'd0, bus.taken},   32'd0);
    chk({nm, ".post.illegal"}, {31'd0, bus.illegal}, 32'd0);
    chk({nm, ".post.pc_next"}, {24'd0, bus.pc_next}, {24'd0, v.exp_next});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    //            op     NZCBV     pc     rdata  tkn   ill   next
    vecs[0]  = '{8'hA0, 5'b01000, 8'h21, 8'h47, 1'b1, 1'b0, 8'h47}; // JZ taken
    vecs[1]  = '{8'hA4, 5'b01000, 8'h21, 8'h00, 1'b0, 1'b0, 8'h22}; // JNZ not taken
    vecs[2]  = '{8'h94, 5'b00000, 8'h10, 8'h5A, 1'b1, 1'b0, 8'h5A}; // JP N=0 Z=0
    vecs[3]  = '{8'h94, 5'b10000, 8'h10, 8'h00, 1'b0, 1'b0, 8'h11}; // JP N=1
    vecs[4]  = '{8'h94, 5'b01000, 8'h10, 8'h00, 1'b0, 1'b0, 8'h11}; // JP Z=1
    vecs[5]  = '{8'h80, 5'b00000, 8'h33, 8'hC3, 1'b1, 1'b0, 8'hC3}; // JMP
    vecs[6]  = '{8'hA4, 5'b01000, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00}; // pc wrap
    vecs[7]  = '{8'h30, 5'b00000, 8'h44, 8'h00, 1'b0, 1'b1, 8'h00}; // illegal, pc_next held
    vecs[8]  = '{8'h90, 5'b10000, 8'h50, 8'h61, 1'b1, 1'b0, 8'h61}; // JN
    vecs[9]  = '{8'h98, 5'b00000, 8'h60, 8'h00, 1'b0, 1'b0, 8'h61}; // JV not taken
    vecs[10] = '{8'h9C, 5'b00000, 8'h70, 8'h12, 1'b1, 1'b0, 8'h12}; // JNV
    vecs[11] = '{8'hB0, 5'b00000, 8'h80, 8'h00, 1'b0, 1'b0, 8'h81}; // JC not taken
    vecs[12] = '{8'hB4, 5'b00000, 8'h90, 8'h34, 1'b1, 1'b0, 8'h34}; // JNC
    vecs[13] = '{8'hB8, 5'b00010, 8'hA0, 8'h56, 1'b1, 1'b0, 8'h56}; // JB
    vecs[14] = '{8'hBC, 5'b00010, 8'hB0, 8'h00, 1'b0, 1'b0, 8'hB1}; // JNB not taken
    vecs[15] = '{8'h83, 5'b00000, 8'hC0, 8'h78, 1'b1, 1'b0, 8'h78}; // JMP, low bits ignored
    vecs[16] = '{8'hFC, 5'b11111, 8'hD0, 8'h00, 1'b0, 1'b1, 8'h78}; // illegal

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    drive_req(8'h00, 5'b00000, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // JC with ready delayed 3 cycles; inputs and start churn during READ.
    drive_req(8'hB0, 5'b00100, 8'h5C);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("slow.c1.mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("slow.c1.mem_addr", {24'd0, bus.mem_addr}, 32'h5C);
    for (int k = 0; k < 3; k++) begin
      bus.pc_in     = ~bus.pc_in;
      bus.c_in      = ~bus.c_in;
      bus.z_in      = ~bus.z_in;
      bus.opcode    = (k == 1) ? 8'h30 : 8'hA4;
      bus.start     = (k != 1);
      bus.mem_rdata = 8'h11 * (k + 1);
      @(posedge clk); #1;
      chk($sformatf("slow.w%0d.mem_req", k),  {31'd0, bus.mem_req},  32'd1);
      chk($sformatf("slow.w%0d.mem_addr", k), {24'd0, bus.mem_addr}, 32'h5C);
      chk($sformatf("slow.w%0d.done", k),     {31'd0, bus.done},     32'd0);
      chk($sformatf("slow.w%0d.busy", k),     {31'd0, bus.busy},     32'd1);
    end
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'hE7;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    chk("slow.done",    {31'd0, bus.done},    32'd1);
    chk("slow.taken",   {31'd0, bus.taken},   32'd1);
    chk("slow.pc_load", {31'd0, bus.pc_load}, 32'd1);
    chk("slow.pc_next", {24'd0, bus.pc_next}, 32'hE7);
    chk("slow.mem_req", {31'd0, bus.mem_req}, 32'd0);
    // Start presented during DONE must be dropped.
    drive_req(8'hA4, 5'b00000, 8'h01);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("slow.ign.done",    {31'd0, bus.done},    32'd0);
    chk("slow.ign.busy",    {31'd0, bus.busy},    32'd0);
    chk("slow.ign.pc_next", {24'd0, bus.pc_next}, 32'hE7);
    // Stray mem_ready in IDLE does nothing.
    for (int k = 0; k < 3; k++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 8'h3C;
      @(posedge clk); #1;
      chk($sformatf("idle_rdy%0d.done", k),    {31'd0, bus.done},    32'd0);
      chk($sformatf("idle_rdy%0d.busy", k),    {31'd0, bus.busy},    32'd0);
      chk($sformatf("idle_rdy%0d.pc_next", k), {24'd0, bus.pc_next}, 32'hE7);
    end
    bus.mem_ready = 1'b0;

    // Reset in the middle of READ aborts the fetch without any PC update.
    drive_req(8'h80, 5'b00000, 8'h10);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("abort.c1.mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("abort.async");
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h99;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort.p%0d.pc_load", k), {31'd0, bus.pc_load}, 32'd0);
      chk($sformatf("abort.p%0d.done", k),    {31'd0, bus.done},    32'd0);
      chk($sformatf("abort.p%0d.busy", k),    {31'd0, bus.busy},    32'd0);
      chk($sformatf("abort.p%0d.mem_req", k), {31'd0, bus.mem_req}, 32'd0);
    end
    bus.mem_ready = 1'b0;
    // Recovery from IDLE; pc_next still holds its reset value of 0.
    vrec = '{8'h30, 5'b00000, 8'h20, 8'h00, 1'b0, 1'b1, 8'h00};
    run_vec(vrec, "recover.ill");
    vrec = '{8'hA4, 5'b00000, 8'h20, 8'hBB, 1'b1, 1'b0, 8'hBB};
    run_vec(vrec, "recover.jnz");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jump_control.md
Name: jump_control

Overview:
- Conditional-branch sequencer for the 8-bit accumulator CPU; the consumer of the N/Z/C/B/V status flags.
- On a start pulse it decodes the jump opcode and samples the flags. If the jump is taken, it fetches the operand byte (the target address) from memory and loads it into the PC. If not taken, it advances the PC past the operand byte.
- Sits between the instruction register / status flags and the PC / memory-interface arbitration in the control unit.

Parameters:
- ADDR_W, 8, width of the PC, memory address and operand.
- DATA_W, 8, width of memory read data; must be >= ADDR_W; the target is taken from rdata[ADDR_W-1:0].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; opcode, flags and pc_in are valid in this cycle.
- opcode  in  8  instruction byte from the IR.
- n_in, z_in, c_in, b_in, v_in  in  1 each  current status flags.
- pc_in  in  ADDR_W  address of the operand byte (PC already past the opcode).
- mem_req  out  1  operand read request.
- mem_addr  out  ADDR_W  operand read address.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.
- mem_ready  in  1  read completion.
- pc_load  out  1  one-cycle strobe: PC <= pc_next.
- pc_next  out  ADDR_W  new PC value.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion strobe.
- taken  out  1  condition result; valid while done=1.
- illegal  out  1  opcode is not a jump; valid while done=1.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, and every output is 0 (mem_req, mem_addr, pc_load, pc_next, busy, done, taken, illegal).
- Decode is on opcode[7:2]. A start with any other opcode is illegal.
  - JMP 0x80: always taken.
  - JN 0x90: taken if N=1.
  - JP 0x94: taken if N=0 and Z=0.
  - JV 0x98: taken if V=1.
  - JNV 0x9C: taken if V=0.
  - JZ 0xA0: taken if Z=1.
  - JNZ 0xA4: taken if Z=0.
  - JC 0xB0: taken if C=1.
  - JNC 0xB4: taken if C=0.
  - JB 0xB8: taken if B=1.
  - JNB 0xBC: taken if B=0.
- The following values are latched in IDLE on the start edge: opcode, the five flags and pc_in. Flag or pc_in changes after that edge have no effect on the operation in progress.
- States:
  - IDLE:
    - start & taken -> READ.
    - start & not taken -> DONE, with pc_next=pc_in+1.
    - start & illegal -> DONE, with illegal=1 and no pc_load.
  - READ:
    - mem_req=1 and mem_addr=latched pc. Both are held stable until mem_ready.
    - When mem_ready=1: capture mem_rdata[ADDR_W-1:0] into pc_next, then -> DONE.
  - DONE:
    - done=1 for one cycle.
    - pc_load=1 unless illegal.
    - taken reflects the decision.
    - -> IDLE.
- Latency, counting the start edge as cycle 0:
  - not-taken or illegal: DONE in cycle 1.
  - taken: READ in cycle 1; DONE in the cycle after the first cycle with mem_ready=1 (earliest cycle 2).
- pc_in+1 wraps modulo 2^ADDR_W (0xFF -> 0x00 at the default width).
- start while busy=1 or in DONE is ignored; it is neither queued nor counted.
- mem_ready while mem_req=0 is ignored.
- mem_req deasserts in the cycle after the accepting mem_ready.
- Reset asserted mid-READ aborts the operation: no pc_load and no done; mem_req drops immediately.
- pc_next holds its last value outside DONE; taken and illegal are cleared on leaving DONE.

Test Plan:
- Reset: hold reset_n=0 mid-READ -> all outputs 0 immediately; after release, state is IDLE and no pc_load ever fires for the aborted op.
- JZ 0xA0, Z=1, pc_in=0x21, mem_rdata=0x47 with mem_ready on the first request cycle -> mem_req=1 and mem_addr=0x21 in cycle 1; done=1, taken=1, pc_load=1, pc_next=0x47 in cycle 2.
- JNZ 0xA4, Z=1, pc_in=0x21 -> no mem_req; cycle 1 shows done=1, taken=0, pc_load=1, pc_next=0x22.
- JP 0x94 with {N,Z}=00, 10, 01 -> taken=1, 0, 0. JMP 0x80 with all flags 0 -> taken. Not-taken case with pc_in=0xFF -> pc_next=0x00.
- JC 0xB0, C=1, mem_ready delayed 3 cycles, flags and pc_in toggled and extra start pulses during READ -> mem_addr stable, single done, target equals the data at ready.
- opcode 0x30 (non-jump) -> done=1 and illegal=1 in cycle 1; pc_load=0; mem_req=0.
